// File: rtl/ddr2_port_arbiter.sv
// ddr2_port_arbiter: shares the DDR2 data port between the core data path and a FIFO-buffered DMA write stream.
// Define DDR2_ARB_STATS_EN to add the core_wait_cycles / dma_wait_cycles statistics outputs.
module ddr2_port_arbiter #(
    parameter int unsigned FIFO_DEPTH   = 8,
    parameter int unsigned HIGH_WATER   = 6,
    parameter int unsigned STARVE_LIMIT = 16,
    parameter logic [31:0] DMA_BASE     = 32'h0010_0000,
    parameter int unsigned DMA_WORDS    = 1024
) (
    input  logic                            clock,
    input  logic                            reset,
    input  logic                            core_en,
    input  logic                            core_we,
    input  logic [31:0]                     core_addr,
    input  logic [31:0]                     core_wd,
    output logic [31:0]                     core_rd,
    output logic                            core_stall,
    input  logic                            dma_valid,
    input  logic [31:0]                     dma_data,
    output logic                            ddr2_en,
    output logic                            ddr2_we,
    output logic [31:0]                     ddr2_addr,
    output logic [31:0]                     ddr2_wd,
    input  logic [31:0]                     ddr2_rd,
    input  logic                            ddr2_stall,
    output logic [$clog2(FIFO_DEPTH):0]     fifo_count,
    output logic                            overflow,
    output logic [$clog2(DMA_WORDS)-1:0]    dma_ptr
`ifdef DDR2_ARB_STATS_EN
    ,
    output logic [31:0]                     core_wait_cycles,
    output logic [31:0]                     dma_wait_cycles
`endif
);

    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam int unsigned PW = $clog2(DMA_WORDS);
    localparam int unsigned SW = $clog2(STARVE_LIMIT + 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CORE = 2'd1,
        ST_DMA  = 2'd2
    } state_t;

    state_t          state_r;
    state_t          owner_s;
    logic [31:0]     mem_r [FIFO_DEPTH];
    logic [AW-1:0]   rd_ptr_r;
    logic [AW-1:0]   wr_ptr_r;
    logic [CW-1:0]   count_r;
    logic            overflow_r;
    logic [PW-1:0]   dma_ptr_r;
    logic [SW-1:0]   starve_r;
    logic            dma_pref_s;
    logic            fifo_empty_s;
    logic            fifo_full_s;
    logic            done_s;
    logic            pop_s;
    logic            push_s;
    logic            drop_s;

    assign fifo_empty_s = (count_r == {CW{1'b0}});
    assign fifo_full_s  = (count_r == CW'(FIFO_DEPTH));
    assign dma_pref_s   = (count_r >= CW'(HIGH_WATER)) || (starve_r >= SW'(STARVE_LIMIT));

    // Owner selection: a locked state keeps its owner, IDLE arbitrates this cycle.
    always_comb begin
        owner_s = ST_IDLE;
        if (reset) begin
            owner_s = ST_IDLE;
        end else begin
            case (state_r)
                ST_CORE: owner_s = ST_CORE;
                ST_DMA:  owner_s = ST_DMA;
                ST_IDLE: begin
                    if (!fifo_empty_s && (dma_pref_s || !core_en)) begin
                        owner_s = ST_DMA;
                    end else if (core_en) begin
                        owner_s = ST_CORE;
                    end else begin
                        owner_s = ST_IDLE;
                    end
                end
                default: owner_s = ST_IDLE;
            endcase
        end
    end

    // DDR2 port mux driven by the current owner, combinational for zero added latency.
    always_comb begin
        ddr2_en   = 1'b0;
        ddr2_we   = 1'b0;
        ddr2_addr = 32'h0000_0000;
        ddr2_wd   = 32'h0000_0000;
        case (owner_s)
            ST_CORE: begin
                ddr2_en   = core_en;
                ddr2_we   = core_we;
                ddr2_addr = core_addr;
                ddr2_wd   = core_wd;
            end
            ST_DMA: begin
                ddr2_en   = 1'b1;
                ddr2_we   = 1'b1;
                ddr2_addr = DMA_BASE + 32'(dma_ptr_r);
                ddr2_wd   = mem_r[rd_ptr_r];
            end
            default: begin
                ddr2_en   = 1'b0;
                ddr2_we   = 1'b0;
                ddr2_addr = 32'h0000_0000;
                ddr2_wd   = 32'h0000_0000;
            end
        endcase
    end

    assign done_s     = ddr2_en & ~ddr2_stall;
    assign pop_s      = done_s & (owner_s == ST_DMA);
    // A full FIFO still accepts a word when the head leaves in the same cycle.
    assign push_s     = dma_valid & (~fifo_full_s | pop_s);
    assign drop_s     = dma_valid & fifo_full_s & ~pop_s;
    assign core_stall = ~reset & core_en & ~((owner_s == ST_CORE) & ~ddr2_stall);
    assign core_rd    = ddr2_rd;
    assign fifo_count = count_r;
    assign overflow   = overflow_r;
    assign dma_ptr    = dma_ptr_r;

    // Owner lock: hold the owner while DDR2 stalls its request, release on completion.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r <= ST_IDLE;
        end else if (ddr2_en && ddr2_stall) begin
            state_r <= owner_s;
        end else begin
            state_r <= ST_IDLE;
        end
    end

    // FIFO storage; contents need no reset since occupancy guards every read.
    always_ff @(posedge clock) begin
        if (push_s) begin
            mem_r[wr_ptr_r] <= dma_data;
        end
    end

    // FIFO pointers, occupancy, sticky overflow and ring index.
    always_ff @(posedge clock) begin
        if (reset) begin
            rd_ptr_r   <= {AW{1'b0}};
            wr_ptr_r   <= {AW{1'b0}};
            count_r    <= {CW{1'b0}};
            overflow_r <= 1'b0;
            dma_ptr_r  <= {PW{1'b0}};
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + AW'(1);
            end
            if (pop_s) begin
                rd_ptr_r  <= rd_ptr_r + AW'(1);
                dma_ptr_r <= dma_ptr_r + PW'(1);
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + CW'(1);
                2'b01:   count_r <= count_r - CW'(1);
                default: count_r <= count_r;
            endcase
            if (drop_s) begin
                overflow_r <= 1'b1;
            end
        end
    end

    // Starvation counter: cycles the core won while DMA words were waiting.
    always_ff @(posedge clock) begin
        if (reset) begin
            starve_r <= {SW{1'b0}};
        end else if (pop_s || fifo_empty_s) begin
            starve_r <= {SW{1'b0}};
        end else if ((owner_s == ST_CORE) && (starve_r < SW'(STARVE_LIMIT))) begin
            starve_r <= starve_r + SW'(1);
        end else begin
            starve_r <= starve_r;
        end
    end

`ifdef DDR2_ARB_STATS_EN
    logic [31:0] core_wait_r;
    logic [31:0] dma_wait_r;

    // Saturating wait-cycle statistics for each requester.
    always_ff @(posedge clock) begin
        if (reset) begin
            core_wait_r <= 32'h0000_0000;
            dma_wait_r  <= 32'h0000_0000;
        end else begin
            if (core_stall && (owner_s != ST_CORE) && (core_wait_r != 32'hFFFF_FFFF)) begin
                core_wait_r <= core_wait_r + 32'd1;
            end
            if (!fifo_empty_s && (owner_s != ST_DMA) && (dma_wait_r != 32'hFFFF_FFFF)) begin
                dma_wait_r <= dma_wait_r + 32'd1;
            end
        end
    end

    assign core_wait_cycles = core_wait_r;
    assign dma_wait_cycles  = dma_wait_r;
`endif

endmodule
